div_ctrl: RTL and testbench
===========================

# div_ctrl

EX-stage divide controller: the initiator side of the multi-cycle divider handshake. On a DIV/DIVU it latches the operands and drives `start`/`signed`/operands to the divider. It stalls the pipeline until the divider reports ready, then presents the 64-bit result as a HI/LO write. It short-circuits divide-by-zero without starting the divider and annuls an in-flight divide when the pipeline is flushed. It sits between the EX datapath and the `div` unit, alongside the ALU result mux.

## Interface
- `DATA_W`, 32, operand width; the result is `2*DATA_W`, with HI = remainder and LO = quotient.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `div_req_i` in 1: the EX instruction is DIV/DIVU.
- `div_signed_i` in 1: 1 = DIV, 0 = DIVU.
- `reg1_i` in `DATA_W`: dividend.
- `reg2_i` in `DATA_W`: divisor.
- `flush_i` in 1: pipeline flush (exception or branch kill).
- `stall_others_i` in 1: a later stage holds EX.
- `div_start_o` out 1: start request to the divider.
- `div_signed_o` out 1: signed flag to the divider.
- `div_opdata1_o` out `DATA_W`: dividend to the divider.
- `div_opdata2_o` out `DATA_W`: divisor to the divider.
- `div_annul_o` out 1: abort the divider.
- `div_result_i` in `2*DATA_W`: {remainder, quotient} from the divider.
- `div_ready_i` in 1: divider result valid.
- `stallreq_o` out 1: stall request to the pipeline controller.
- `whilo_o` out 1: HI/LO write enable.
- `hi_o` out `DATA_W`: HI write value.
- `lo_o` out `DATA_W`: LO write value.

## Operation
- States: IDLE, BUSY, HOLD.
- Registered: state, latched signed flag, latched operands, 64-bit result buffer.
- IDLE:
  - `div_req_i & !flush_i & reg2_i != 0`: latch signed flag and operands → BUSY.
  - `div_req_i & !flush_i & reg2_i == 0`: load result buffer with 64'h0 → HOLD; the divider is never started.
  - `stallreq_o = div_req_i & !flush_i`, combinational, so the instruction stays in EX.
- BUSY:
  - `div_start_o = 1`; `div_signed_o` and the operand outputs come from the latched registers and are stable for the whole state.
  - `stallreq_o = 1`.
  - On `div_ready_i`: capture `div_result_i` into the buffer → HOLD.
- HOLD:
  - `div_start_o = 0`, `stallreq_o = 0`, `whilo_o = 1`.
  - `hi_o = buffer[2*DATA_W-1:DATA_W]`, `lo_o = buffer[DATA_W-1:0]`.
  - `stall_others_i` → stay in HOLD, outputs unchanged.
  - Otherwise → IDLE; the instruction advances.
- Outside HOLD: `whilo_o = 0`, `hi_o = lo_o = 0`.
- Outside BUSY: `div_start_o = 0`, `div_signed_o = 0`, operand outputs = 0.
- `div_ready_i` is ignored in IDLE and HOLD. The divider keeps ready high until it sees start low.
- `div_req_i` is ignored in BUSY and HOLD; the request belongs to the held instruction.
- Flush:
  - `flush_i` in any state → IDLE next cycle.
  - `stallreq_o = 0` and `whilo_o = 0` combinationally that cycle.
  - In BUSY, `div_annul_o = 1` for that cycle; otherwise `div_annul_o = 0`.
  - Flush together with `div_ready_i` in BUSY: flush wins and the result is discarded.
- Reset (asserted at any time, including mid-divide): state = IDLE; all registers and outputs = 0. The divider shares `rst` and aborts with it.

## Timing
- Cycle T: IDLE, request seen, `stallreq_o = 1`; BUSY from T+1 with `div_start_o = 1`.
- Cycle R: first cycle with `div_ready_i = 1` in BUSY; HOLD from R+1.
- Stall window:
  - Pipeline stalled from T to R inclusive.
  - `whilo_o` first high at R+1, and at R+1 `div_start_o` is low.
  - Total EX occupancy = (R−T)+2 cycles when `stall_others_i` is low.
- Divide-by-zero: stall for cycle T only; HOLD at T+1; 2 cycles total.
- `stallreq_o`, `whilo_o`, `div_annul_o` and `div_start_o` are combinational decodes of state and inputs. The operand outputs and `hi_o`/`lo_o` are register-driven.

## Structure
- Shared `defines.v` holds:
  - `RegBus` and `DoubleRegBus`.
  - State encodings `DivCtrlIdle`, `DivCtrlBusy`, `DivCtrlHold` (2 bits).
  - `DivStart`/`DivStop` and `DivResultReady`/`DivResultNotReady` constants, shared with the divider.
- No sub-module. Instantiated in the EX stage next to `div`; `stallreq_o` ORs into the EX stall request.

## Test plan
- DIVU 100/7, divider ready after 34 cycles:
  - `stallreq_o` high for 35 cycles.
  - Then `whilo_o = 1`, `hi_o = 2`, `lo_o = 14`.
  - `div_start_o` low on the HOLD cycle.
- DIV −7/2 (0xFFFFFFF9, 0x00000002), `div_signed_o = 1` throughout BUSY: `hi_o = 0xFFFFFFFF`, `lo_o = 0xFFFFFFFD`.
- DIVU 5/0:
  - `div_start_o` never asserted.
  - One stall cycle, then `whilo_o = 1`, `hi_o = lo_o = 0`.
- `flush_i` at BUSY cycle 10:
  - `div_annul_o = 1` that cycle and `stallreq_o = 0`.
  - IDLE next cycle; no `whilo_o`.
  - A following DIVU 9/3 completes with `lo_o = 3`, `hi_o = 0`.
- `stall_others_i` held 3 cycles in HOLD: `whilo_o` and `hi_o`/`lo_o` stable for 4 cycles, then IDLE. `rst` low mid-BUSY: all outputs 0 immediately; IDLE on release.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the EX-stage divide controller and the divider handshake.
package div_ctrl_pkg;

  localparam int REG_W        = 32;
  localparam int DOUBLE_REG_W = 2 * REG_W;

  localparam logic [1:0] DIV_CTRL_IDLE = 2'b00;
  localparam logic [1:0] DIV_CTRL_BUSY = 2'b01;
  localparam logic [1:0] DIV_CTRL_HOLD = 2'b10;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_ctrl.sv
// Initiator side of the multi-cycle divider handshake: latches DIV/DIVU operands,
// stalls EX until the divider is ready, then presents {HI, LO} for one write.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_req_i,
  input  logic                  div_signed_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic                  flush_i,
  input  logic                  stall_others_i,
  output logic                  div_start_o,
  output logic                  div_signed_o,
  output logic [DATA_W-1:0]     div_opdata1_o,
  output logic [DATA_W-1:0]     div_opdata2_o,
  output logic                  div_annul_o,
  input  logic [2*DATA_W-1:0]   div_result_i,
  input  logic                  div_ready_i,
  output logic                  stallreq_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  logic [1:0]          state;
  logic                signed_q;
  logic [DATA_W-1:0]   op1_q;
  logic [DATA_W-1:0]   op2_q;
  logic [2*DATA_W-1:0] result_q;

  logic in_idle;
  logic in_busy;
  logic in_hold;
  logic accept;
  logic div_by_zero;

  assign in_idle     = (state == DIV_CTRL_IDLE);
  assign in_busy     = (state == DIV_CTRL_BUSY);
  assign in_hold     = (state == DIV_CTRL_HOLD);
  assign accept      = in_idle && div_req_i && !flush_i;
  assign div_by_zero = (reg2_i == '0);

  // Operand and result registers are cleared whenever their state is left, so the
  // outputs read them directly and are zero outside BUSY / HOLD without a mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_CTRL_IDLE;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        DIV_CTRL_IDLE: begin
          if (accept) begin
            if (div_by_zero) begin
              result_q <= '0;
              state    <= DIV_CTRL_HOLD;
            end else begin
              signed_q <= div_signed_i;
              op1_q    <= reg1_i;
              op2_q    <= reg2_i;
              state    <= DIV_CTRL_BUSY;
            end
          end
        end
        DIV_CTRL_BUSY: begin
          // Flush beats a simultaneous ready: the result is dropped.
          if (flush_i) begin
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            state    <= DIV_CTRL_IDLE;
          end else if (div_ready_i == DIV_RESULT_READY) begin
            result_q <= div_result_i;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            state    <= DIV_CTRL_HOLD;
          end
        end
        DIV_CTRL_HOLD: begin
          if (flush_i || !stall_others_i) begin
            result_q <= '0;
            state    <= DIV_CTRL_IDLE;
          end
        end
        default: state <= DIV_CTRL_IDLE;
      endcase
    end
  end

  // Control decodes are gated by reset so every output reads zero while it is held.
  assign stallreq_o    = rst && !flush_i && (accept || in_busy);
  assign div_start_o   = (rst && in_busy) ? DIV_START : DIV_STOP;
  assign div_annul_o   = rst && in_busy && flush_i;
  assign whilo_o       = rst && in_hold && !flush_i;
  assign div_signed_o  = signed_q;
  assign div_opdata1_o = op1_q;
  assign div_opdata2_o = op2_q;
  assign hi_o          = result_q[2*DATA_W-1:DATA_W];
  assign lo_o          = result_q[DATA_W-1:0];

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a hand-scripted divider on the other side.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic        stall_others_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_annul_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  div_ctrl #(.DATA_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_req_i      (div_req_i),
    .div_signed_i   (div_signed_i),
    .reg1_i         (reg1_i),
    .reg2_i         (reg2_i),
    .flush_i        (flush_i),
    .stall_others_i (stall_others_i),
    .div_start_o    (div_start_o),
    .div_signed_o   (div_signed_o),
    .div_opdata1_o  (div_opdata1_o),
    .div_opdata2_o  (div_opdata2_o),
    .div_annul_o    (div_annul_o),
    .div_result_i   (div_result_i),
    .div_ready_i    (div_ready_i),
    .stallreq_o     (stallreq_o),
    .whilo_o        (whilo_o),
    .hi_o           (hi_o),
    .lo_o           (lo_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide, runs busy_n BUSY cycles (ready on the last), then
  // spends hold_n extra HOLD cycles under stall_others_i before returning to IDLE.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int busy_n, input logic [63:0] res,
                         input int hold_n);
    int   stalls = 0;
    int   whilo_n = 0;
    logic busy_ok = 1'b1;
    logic hold_ok = 1'b1;
    div_req_i = 1'b1; div_signed_i = sgn; reg1_i = a; reg2_i = b;
    #1;
    if (stallreq_o) stalls++;
    check({tag, " start_T"}, div_start_o, 1'b0);
    tick();
    for (int i = 1; i <= busy_n; i++) begin
      if (i == 2) begin
        reg1_i = ~a; reg2_i = ~b; div_signed_i = ~sgn;
      end
      div_ready_i  = (i == busy_n);
      div_result_i = (i == busy_n) ? res : 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      if (stallreq_o) stalls++;
      if (div_start_o !== 1'b1 || div_signed_o !== sgn || div_opdata1_o !== a ||
          div_opdata2_o !== b || whilo_o !== 1'b0)
        busy_ok = 1'b0;
      tick();
    end
    div_req_i = 1'b1;
    for (int j = 0; j <= hold_n; j++) begin
      stall_others_i = (j < hold_n);
      #1;
      if (j == 0) begin
        check({tag, " stall_cycles"}, stalls, busy_n + 1);
        check({tag, " busy_outputs"}, busy_ok, 1'b1);
        check({tag, " start_hold"}, div_start_o, 1'b0);
        check({tag, " stallreq_hold"}, stallreq_o, 1'b0);
        check({tag, " hi"}, hi_o, res[63:32]);
        check({tag, " lo"}, lo_o, res[31:0]);
      end
      if (whilo_o) whilo_n++;
      if (hi_o !== res[63:32] || lo_o !== res[31:0] || div_opdata1_o !== 32'h0) hold_ok = 1'b0;
      tick();
      div_ready_i = 1'b0;
    end
    stall_others_i = 1'b0;
    div_req_i = 1'b0;
    #1;
    check({tag, " whilo_cycles"}, whilo_n, hold_n + 1);
    check({tag, " hold_stable"}, hold_ok, 1'b1);
    check({tag, " idle_whilo"}, whilo_o, 1'b0);
    check({tag, " idle_hilo"}, {hi_o, lo_o}, 64'h0);
  endtask

  initial begin
    rst = 1'b0;
    div_req_i = 1'b0; div_signed_i = 1'b0; reg1_i = '0; reg2_i = '0;
    flush_i = 1'b0; stall_others_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;
    #1;
    check("reset_ctrl", {stallreq_o, whilo_o, div_start_o, div_annul_o, div_signed_o}, 5'b0);
    check("reset_data", {div_opdata1_o, div_opdata2_o, hi_o, lo_o}, 128'h0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("idle_no_req_stall", stallreq_o, 1'b0);
    tick();

    // DIVU 100/7: remainder 2, quotient 14
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34, {32'd2, 32'd14}, 0);
    tick();

    // DIV -7/2: remainder -1, quotient -3
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    tick();

    // DIVU 5/0 short-circuits
    div_req_i = 1'b1; div_signed_i = 1'b0; reg1_i = 32'd5; reg2_i = 32'd0;
    #1;
    check("dz_stall_T", stallreq_o, 1'b1);
    check("dz_start_T", div_start_o, 1'b0);
    tick();
    div_req_i = 1'b0;
    #1;
    check("dz_whilo", whilo_o, 1'b1);
    check("dz_hilo", {hi_o, lo_o}, 64'h0);
    check("dz_start_hold", div_start_o, 1'b0);
    check("dz_stall_hold", stallreq_o, 1'b0);
    tick();
    #1;
    check("dz_idle_whilo", whilo_o, 1'b0);
    tick();

    // Flush on BUSY cycle 10
    div_req_i = 1'b1; reg1_i = 32'd50; reg2_i = 32'd5;
    #1;
    tick();
    for (int i = 1; i < 10; i++) tick();
    flush_i = 1'b1;
    #1;
    check("flush_annul", div_annul_o, 1'b1);
    check("flush_stallreq", stallreq_o, 1'b0);
    check("flush_whilo", whilo_o, 1'b0);
    tick();
    flush_i = 1'b0; div_req_i = 1'b0;
    #1;
    check("flush_idle", {div_start_o, div_annul_o, stallreq_o, whilo_o}, 4'b0);
    check("flush_ops_cleared", {div_opdata1_o, div_opdata2_o}, 64'h0);
    tick();
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 4, {32'd0, 32'd3}, 0);
    tick();

    // stall_others_i held three HOLD cycles
    run_div("hold_stall", 1'b0, 32'd17, 32'd5, 3, {32'd2, 32'd3}, 3);
    tick();

    // Flush coincident with ready: result discarded; ready ignored in IDLE
    div_req_i = 1'b1; reg1_i = 32'd30; reg2_i = 32'd4;
    #1;
    tick();
    tick();
    div_req_i = 1'b0; flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = {32'd2, 32'd7};
    #1;
    check("flush_ready_annul", div_annul_o, 1'b1);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_ready_whilo", whilo_o, 1'b0);
    check("flush_ready_hilo", {hi_o, lo_o}, 64'h0);
    tick();
    div_ready_i = 1'b0;
    #1;
    check("idle_ready_ignored", whilo_o, 1'b0);
    tick();

    // Reset asserted mid-BUSY
    div_req_i = 1'b1; div_signed_i = 1'b1; reg1_i = 32'd20; reg2_i = 32'd4;
    #1;
    tick(); tick();
    #1;
    check("pre_rst_start", div_start_o, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_mid_ctrl", {div_start_o, div_signed_o, stallreq_o, whilo_o, div_annul_o}, 5'b0);
    check("rst_mid_data", {div_opdata1_o, div_opdata2_o, hi_o, lo_o}, 128'h0);
    tick();
    div_req_i = 1'b0; rst = 1'b1;
    #1;
    tick();
    check("rst_release_idle", {div_start_o, stallreq_o, whilo_o}, 3'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
